input_debounce_sync: RTL
========================

// Module: input_debounce_sync
// PURPOSE
//  Conditions the raw 8-bit pad bus (ui_in / uio_in) before it reaches the
//  combining logic of the top-level tile. One instance per input bus.
//  Per bit: 2-flop synchroniser, then a stability-counter debouncer. Emits
//  the clean level plus one-cycle rise/fall pulses and an any-change strobe.
// PARAMETERS
//  WIDTH      8   number of input bits conditioned
//  DB_CYCLES  4   consecutive cycles a new synchronised level must persist
//                 before it is accepted; legal range 1..255
// PORTS
//  clk    in   1      system clock; every flop is rising-edge
//  rst    in   1      reset, synchronous, active-high
//  ena    in   1      1 = debounce counters run; 0 = counters and q hold
//  din    in   WIDTH  raw asynchronous pad inputs
//  q      out  WIDTH  debounced level, registered
//  rise   out  WIDTH  1-cycle pulse per bit when that q bit goes 0->1
//  fall   out  WIDTH  1-cycle pulse per bit when that q bit goes 1->0
//  chg    out  1      1-cycle pulse, equal to |(rise|fall)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): s1, s2, every cnt, q, rise, fall and chg
//    are cleared to 0. rst takes priority over ena and din.
//  - Synchroniser: s1 <= din; s2 <= s1. This stage runs regardless of ena.
//  - Counter: one 8-bit cnt per bit. Update rules when ena=1:
//      * s2[i] == q[i]: cnt[i] <= 0.
//      * s2[i] != q[i] and cnt[i] == DB_CYCLES-1: q[i] <= s2[i] and
//        cnt[i] <= 0.
//      * Otherwise: cnt[i] <= cnt[i] + 1. The counter never wraps.
//  - ena=0: cnt, q, rise, fall and chg are held, except that rise, fall
//    and chg are forced to 0. Counting resumes where it stopped.
//  - Latency: let E0 be the first edge at which a new din level is sampled.
//    If din is then held, q takes the new level at edge E0+DB_CYCLES+1.
//  - Glitch: if s2[i] returns to q[i] before the threshold is reached,
//    cnt[i] is cleared, and q[i], rise[i] and fall[i] are unaffected.
//  - Edge pulses: registered. They are asserted for exactly the one cycle
//    in which q holds its new value. Bits are independent, so several
//    rise and fall bits may be set together.
//  - A bit toggling every cycle never reaches the threshold, so q stays
//    put.
//  - Reset mid-count discards the partial count. After reset, input bits
//    held at 1 rise again after the full latency and produce rise pulses.
// CONFIGURATION
//  - INPUT_DEBOUNCE_EDGE_EN defined: the rise, fall and chg registers and
//    logic exist, with the behaviour described above.
//  - Not defined: rise, fall and chg are tied to constant 0 and no edge
//    flops are built. q behaviour is identical in both builds.
// TESTING (WIDTH=8, DB_CYCLES=4, edge macro defined unless noted)
//  1. rst=1 for 3 edges with din=8'hFF -> q=8'h00, rise=fall=0, chg=0.
//  2. din 8'h00->8'h01 held, E0 = first sampling edge -> q=8'h01 after
//     edge E0+5, never earlier; rise=8'h01 and chg=1 for exactly 1 cycle.
//  3. din[3] high for 3 cycles then low -> q stays 8'h00; no rise, fall or
//     chg pulse.
//  4. From q=8'h0F, din 8'h0F->8'hF0 -> q=8'hF0 on a single edge;
//     rise=8'hF0, fall=8'h0F, chg=1 in that same cycle only.
//  5. ena=0 for 10 cycles starting mid-count (cnt=2) -> q holds; with
//     ena=1 again, q updates 2 cycles later (at cnt=3 -> accept).
//  6. rst=1 for 1 edge mid-count with din=8'hAA held -> all outputs 0, then
//     q=8'hAA exactly DB_CYCLES+2 edges after reset release.
//     Without the macro: rise, fall and chg stay 0 throughout.

Source files
------------

// File: rtl/input_debounce_sync.sv
// -----------------------------------------------------------------------------
// input_debounce_sync
//   Conditions a raw asynchronous pad bus before it reaches the tile's
//   combining logic. Each bit passes through a 2-flop synchroniser and then a
//   stability-counter debouncer. A new synchronised level is accepted only
//   after it has persisted for DB_CYCLES consecutive enabled cycles.
//
//   Build option:
//     INPUT_DEBOUNCE_EDGE_EN  defined   -> registered rise/fall/chg pulses
//                             undefined -> rise/fall/chg tied to 0, no flops
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      synchronous active-high reset
//   ena   in   1      1 = debounce counters run, 0 = counters and q hold
//   din   in   WIDTH  raw asynchronous pad inputs
//   q     out  WIDTH  debounced level (registered)
//   rise  out  WIDTH  one-cycle pulse when a q bit goes 0->1
//   fall  out  WIDTH  one-cycle pulse when a q bit goes 1->0
//   chg   out  1      one-cycle pulse, |(rise|fall)
// -----------------------------------------------------------------------------
module input_debounce_sync #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4   // legal range 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);

  // Terminal count: a mismatch seen with cnt already at DB_CYCLES-1 is the
  // DB_CYCLES-th consecutive mismatching cycle, so it is accepted.
  localparam logic [7:0] CNT_TC = 8'(DB_CYCLES - 1);

  logic [WIDTH-1:0]      s1;
  logic [WIDTH-1:0]      s2;
  logic [WIDTH-1:0]      q_nxt;
  logic [WIDTH-1:0][7:0] cnt;
  logic [WIDTH-1:0][7:0] cnt_nxt;

  // Synchroniser runs independently of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_TC) begin
          q_nxt[i]   = s2[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  // Pulses are registered alongside q so they line up with the cycle in
  // which q first shows its new value. q_nxt equals q whenever ena=0, so
  // the pulses are naturally forced low while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
      chg  <= 1'b0;
    end else begin
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
      chg  <= |(q_nxt ^ q);
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
  assign chg  = 1'b0;
`endif

endmodule
